addseq_limb_sequencer: RTL and testbench



---
 rtl/addseq_limb_sequencer_if.sv | 43 ++++
 rtl/addseq_limb_sequencer.sv | 111 +++++++++++
 tb/tb_addseq_limb_sequencer.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/addseq_limb_sequencer_if.sv
// Request/result and adder-side bus for addseq_limb_sequencer.
// slave: the sequencer. master: the requester plus adder side (e.g. a bench).
// Macro ADDSEQ_SUBTRACT_EN adds the iSub request bit.
interface addseq_limb_sequencer_if #(
  parameter int W    = 64,
  parameter int LIMB = 16
);
  logic            iValid;
  logic            oAccept;
  logic [W-1:0]    iA;
  logic [W-1:0]    iB;
  logic            iCarryIn;
`ifdef ADDSEQ_SUBTRACT_EN
  logic            iSub;
`endif
  logic            oAddValid;
  logic [LIMB-1:0] oAddX;
  logic [LIMB-1:0] oAddY;
  logic            oAddCarryIn;
  logic [LIMB-1:0] iAddZ;
  logic            iAddCarryOut;
  logic            iAddReady;
  logic [W-1:0]    oSum;
  logic            oCarryOut;
  logic            oDone;
  logic            oError;

  modport slave (
`ifdef ADDSEQ_SUBTRACT_EN
    input  iSub,
`endif
    input  iValid, iA, iB, iCarryIn, iAddZ, iAddCarryOut, iAddReady,
    output oAccept, oAddValid, oAddX, oAddY, oAddCarryIn, oSum, oCarryOut, oDone, oError
  );

  modport master (
`ifdef ADDSEQ_SUBTRACT_EN
    output iSub,
`endif
    output iValid, iA, iB, iCarryIn, iAddZ, iAddCarryOut, iAddReady,
    input  oAccept, oAddValid, oAddX, oAddY, oAddCarryIn, oSum, oCarryOut, oDone, oError
  );
endinterface

// File: rtl/addseq_limb_sequencer.sv
// addseq_limb_sequencer: splits one W-bit add into LIMB-wide transactions
// for the pipelined adder (LSB limb first), chains each limb's carry-out
// into the next limb's carry-in and reassembles the W-bit sum.
// Optional feature: define ADDSEQ_SUBTRACT_EN for bus.iSub (computes A - B).
module addseq_limb_sequencer #(
  parameter int W       = 64,
  parameter int LIMB    = 16,
  parameter int TIMEOUT = 15
) (
  input logic                    clk,
  input logic                    resetn,
  addseq_limb_sequencer_if.slave bus
);
  localparam int N  = W / LIMB;
  localparam int KW = (N > 1) ? $clog2(N) : 1;
  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t         state, state_nxt;
  logic [W-1:0]   a_q, b_q, sum_q;
  logic           carry_q, cout_q, err_q;
  logic [KW-1:0]  k_q;
  logic [CW-1:0]  cnt_q;
  logic           sub_in;
  logic           last_limb, timeout_hit;

`ifdef ADDSEQ_SUBTRACT_EN
  assign sub_in = bus.iSub;
`else
  assign sub_in = 1'b0;
`endif

  assign last_limb   = (k_q == KW'(N - 1));
  assign timeout_hit = (cnt_q == CW'(TIMEOUT - 1));

  // Subtraction is folded into the captured operands: B is stored inverted
  // and the running carry starts at 1, so the limb datapath is add-only.
  assign bus.oAccept     = (state == IDLE);
  assign bus.oAddValid   = (state == ISSUE);
  assign bus.oAddX       = a_q[k_q*LIMB +: LIMB];
  assign bus.oAddY       = b_q[k_q*LIMB +: LIMB];
  assign bus.oAddCarryIn = carry_q;
  assign bus.oSum        = sum_q;
  assign bus.oCarryOut   = cout_q;
  assign bus.oDone       = (state == DONE);
  assign bus.oError      = (state == DONE) && err_q;

  // State register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.iValid) state_nxt = ISSUE;
      ISSUE:   state_nxt = WAIT;
      WAIT: begin
        if (bus.iAddReady) state_nxt = last_limb ? DONE : ISSUE;
        else if (timeout_hit) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Operand capture, limb index, carry chain, result assembly and timeout
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      err_q   <= 1'b0;
      k_q     <= '0;
      cnt_q   <= '0;
    end else begin
      case (state)
        IDLE: begin
          k_q   <= '0;
          cnt_q <= '0;
          err_q <= 1'b0;
          if (bus.iValid) begin
            a_q     <= bus.iA;
            b_q     <= sub_in ? ~bus.iB : bus.iB;
            carry_q <= sub_in ? 1'b1 : bus.iCarryIn;
            sum_q   <= '0;
            cout_q  <= 1'b0;
          end
        end
        WAIT: begin
          if (bus.iAddReady) begin
            sum_q[k_q*LIMB +: LIMB] <= bus.iAddZ;
            carry_q <= bus.iAddCarryOut;
            cnt_q   <= '0;
            if (last_limb) cout_q <= bus.iAddCarryOut;
            else           k_q    <= k_q + 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
            if (timeout_hit) err_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_addseq_limb_sequencer.sv
// Bench for addseq_limb_sequencer: behavioural adder with configurable
// latency, timeline-based reference model checked every cycle, plus
// literal expectations for the directed scenarios.
module tb_addseq_limb_sequencer;
  localparam int W = 64, LIMB = 16, TIMEOUT = 15, N = W / LIMB;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  addseq_limb_sequencer_if #(.W(W), .LIMB(LIMB)) bus ();
  addseq_limb_sequencer #(.W(W), .LIMB(LIMB), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .resetn(resetn), .bus(bus));

  int n_chk = 0, n_pass = 0;
  int cyc = 0;
  always @(posedge clk) cyc++;

  // reference context for the operation in flight
  bit           op_valid = 0, in_reset = 1;
  int           a0 = 0, mL = 2, mDrop = N, issues = 0;
  logic [W-1:0] mA = '0, mB = '0;
  bit           mCin = 0;

  // observation logs
  int           iss_t[$];
  bit           iss_c[$];
  int           acc_q[$];
  int           done_t = -1;
  logic [W-1:0] done_sum = '0;
  bit           done_cout = 0, done_err = 0;

  typedef struct {
    bit accept, addvalid, done, err, cout, cin;
    logic [W-1:0] sum;
    logic [LIMB-1:0] x, y;
  } exp_t;

  task automatic chk(input string name, input logic [W:0] act, input logic [W:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (time %0t)", name, act, exp, $time);
  endtask

  function automatic logic [W:0] lmask(input int nl);
    logic [W:0] one = 1;
    return (one << (LIMB * nl)) - 1;
  endfunction

  function automatic int end_t();
    return (mDrop < N) ? 2 + mDrop * (mL + 1) + TIMEOUT : N * (mL + 1) + 1;
  endfunction

  // Expected outputs in cycle t after the accept edge, from timeline arithmetic
  function automatic exp_t model(input int t);
    exp_t e;
    logic [W:0] full, low, m;
    int endt, k, ncomp;
    endt  = end_t();
    full  = {1'b0, mA} + {1'b0, mB} + mCin;
    ncomp = 0;
    for (int j = 0; j < N; j++)
      if (j < mDrop && 1 + j * (mL + 1) + mL < t) ncomp++;
    e.sum      = full[W-1:0] & lmask(ncomp)[W-1:0];
    e.cout     = (t >= endt && mDrop >= N) ? full[W] : 1'b0;
    e.accept   = (t > endt);
    e.done     = (t == endt);
    e.err      = e.done && (mDrop < N);
    k          = (t - 1) / (mL + 1);
    e.addvalid = (t < endt) && ((t - 1) % (mL + 1) == 0) && (k <= mDrop) && (k < N);
    if (k >= N) k = 0;
    m     = lmask(k);
    low   = ({1'b0, mA} & m) + ({1'b0, mB} & m) + mCin;
    e.cin = low[LIMB * k];
    e.x   = mA[k*LIMB +: LIMB];
    e.y   = mB[k*LIMB +: LIMB];
    return e;
  endfunction

  // Compare process: every cycle, DUT vs model
  initial begin
    exp_t e;
    int t;
    forever begin
      @(negedge clk);
      if (in_reset) continue;
      if (bus.iValid && bus.oAccept) acc_q.push_back(cyc);
      if (!op_valid) begin
        chk("idle_accept", bus.oAccept, 1);
        chk("idle_addvalid", bus.oAddValid, 0);
        chk("idle_done", bus.oDone, 0);
        chk("idle_error", bus.oError, 0);
        chk("idle_sum", bus.oSum, 0);
        chk("idle_cout", bus.oCarryOut, 0);
        continue;
      end
      t = cyc - a0;
      e = model(t);
      if (bus.oAddValid) begin iss_t.push_back(t); iss_c.push_back(bus.oAddCarryIn); end
      if (bus.oDone) begin
        done_t = t; done_sum = bus.oSum; done_cout = bus.oCarryOut; done_err = bus.oError;
      end
      chk("accept", bus.oAccept, e.accept);
      chk("addvalid", bus.oAddValid, e.addvalid);
      chk("done", bus.oDone, e.done);
      chk("error", bus.oError, e.err);
      chk("sum", bus.oSum, e.sum);
      chk("cout", bus.oCarryOut, e.cout);
      if (e.addvalid) begin
        chk("addx", bus.oAddX, e.x);
        chk("addy", bus.oAddY, e.y);
        chk("addcin", bus.oAddCarryIn, e.cin);
      end
    end
  end

  // Behavioural adder: responds L cycles after each oAddValid, never for limb mDrop;
  // injects stray readies only where they must be ignored.
  initial begin
    bit pend = 0;
    int due = 0;
    logic [LIMB:0] rsp = '0;
    bus.iAddReady = 0; bus.iAddZ = '0; bus.iAddCarryOut = 0;
    forever begin
      @(posedge clk);
      #2;
      bus.iAddReady = 0;
      if (!resetn) begin pend = 0; continue; end
      if (pend && cyc == due) begin
        bus.iAddReady = 1; bus.iAddZ = rsp[LIMB-1:0]; bus.iAddCarryOut = rsp[LIMB]; pend = 0;
      end else if (!pend && (bus.oAccept || bus.oDone || bus.oAddValid) && $urandom_range(0, 3) == 0) begin
        bus.iAddReady = 1; bus.iAddZ = LIMB'($urandom); bus.iAddCarryOut = 1'($urandom);
      end
      if (bus.oAddValid) begin
        if (issues != mDrop) begin
          pend = 1; due = cyc + mL;
          rsp = {1'b0, bus.oAddX} + {1'b0, bus.oAddY} + {{LIMB{1'b0}}, bus.oAddCarryIn};
        end
        issues++;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    iss_t.delete(); iss_c.delete(); done_t = -1; done_err = 0; done_cout = 0; done_sum = '0;
  endtask

  // Presents one request, tracks it through to the first idle cycle after done
  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input bit cin,
                          input bit sub, input int lat, input int drop, input bit keep);
    bit s = sub;
`ifndef ADDSEQ_SUBTRACT_EN
    s = 0;
`endif
    bus.iValid = 1; bus.iA = a; bus.iB = b; bus.iCarryIn = cin;
`ifdef ADDSEQ_SUBTRACT_EN
    bus.iSub = s;
`endif
    step();
    a0 = cyc - 1; mA = a; mB = s ? ~b : b; mCin = s ? 1'b1 : cin;
    mL = lat; mDrop = drop; issues = 0; op_valid = 1;
    clear_logs();
    if (!keep) bus.iValid = 0;
    bus.iA = {$urandom, $urandom}; bus.iB = {$urandom, $urandom}; bus.iCarryIn = 1'($urandom);
`ifdef ADDSEQ_SUBTRACT_EN
    bus.iSub = 1'($urandom);
`endif
  endtask

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input bit cin,
                        input bit sub, input int lat, input int drop, input bit keep);
    start_op(a, b, cin, sub, lat, drop, keep);
    repeat (end_t()) step();
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_accept"}, bus.oAccept, 1);
    chk({tag, "_addvalid"}, bus.oAddValid, 0);
    chk({tag, "_addx"}, bus.oAddX, 0);
    chk({tag, "_addy"}, bus.oAddY, 0);
    chk({tag, "_addcin"}, bus.oAddCarryIn, 0);
    chk({tag, "_sum"}, bus.oSum, 0);
    chk({tag, "_cout"}, bus.oCarryOut, 0);
    chk({tag, "_done"}, bus.oDone, 0);
    chk({tag, "_error"}, bus.oError, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

  initial begin
    logic [W-1:0] a, b;
    bus.iValid = 0; bus.iA = '0; bus.iB = '0; bus.iCarryIn = 0;
`ifdef ADDSEQ_SUBTRACT_EN
    bus.iSub = 0;
`endif
    repeat (2) @(posedge clk);
    #1;
    chk_reset_outputs("reset");
    #2; resetn = 1; in_reset = 0;
    step();

    // all-ones plus one: full carry ripple through every limb
    run_op({W{1'b1}}, 64'd1, 0, 0, 2, N, 0);
    chk("t1_issue_count", iss_t.size(), 4);
    for (int i = 0; i < 4; i++) begin
      chk("t1_issue_cycle", (i < iss_t.size()) ? iss_t[i] : -1, 1 + 3 * i);
      chk("t1_issue_cin", (i < iss_c.size()) ? iss_c[i] : 1'bx, (i == 0) ? 0 : 1);
    end
    chk("t1_done_cycle", done_t, 13);
    chk("t1_sum", done_sum, 0);
    chk("t1_cout", done_cout, 1);

    run_op(64'h0123_4567_89AB_CDEF, 64'h1111_1111_1111_1111, 1, 0, 2, N, 0);
    chk("t2_sum", done_sum, 64'h1234_5678_9ABC_DF01);
    chk("t2_cout", done_cout, 0);
    chk("t2_error", done_err, 0);

    // iValid held high: one accept per 14-cycle slot
    acc_q.delete();
    run_op({$urandom, $urandom}, {$urandom, $urandom}, 0, 0, 2, N, 1);
    run_op({$urandom, $urandom}, {$urandom, $urandom}, 1, 0, 2, N, 1);
    bus.iValid = 0;
    chk("t3_accept_count", acc_q.size(), 2);
    chk("t3_accept_gap", (acc_q.size() >= 2) ? acc_q[1] - acc_q[0] : -1, 14);

    // adder never answers limb 1
    run_op(64'h1111_2222_3333_F000, 64'h0000_0000_0000_2000, 0, 0, 2, 1, 0);
    chk("t4_done_cycle", done_t, 20);
    chk("t4_error", done_err, 1);
    chk("t4_sum", done_sum, 64'h0000_0000_0000_1000);
    chk("t4_cout", done_cout, 0);

    // reset in cycle 5 of an operation
    start_op({$urandom, $urandom}, {$urandom, $urandom}, 1, 0, 2, N, 0);
    repeat (4) step();
    #2; resetn = 0; in_reset = 1;
    #1;
    chk_reset_outputs("midreset");
    @(posedge clk);
    #3; resetn = 1; op_valid = 0; in_reset = 0;
    step();
    chk("post_reset_accept", bus.oAccept, 1);
    run_op(64'hFFFF_0000_FFFF_0000, 64'h0001_FFFF_0001_FFFF, 1, 0, 2, N, 0);
    chk("t5_done_cycle", done_t, 13);
    chk("t5_sum", done_sum, 64'h0001_0000_0001_0000);
    chk("t5_cout", done_cout, 1);

`ifdef ADDSEQ_SUBTRACT_EN
    run_op(64'd5, 64'd7, 1, 1, 2, N, 0);
    chk("t6_sub_sum", done_sum, 64'hFFFF_FFFF_FFFF_FFFE);
    chk("t6_sub_cout", done_cout, 0);
    run_op(64'd7, 64'd5, 0, 1, 2, N, 0);
    chk("t6b_sub_sum", done_sum, 64'd2);
    chk("t6b_sub_cout", done_cout, 1);
`endif

    // randomized requests, latencies and occasional timeouts
    for (int i = 0; i < 24; i++) begin
      a = {$urandom, $urandom};
      b = ($urandom_range(0, 3) == 0) ? ~a : {$urandom, $urandom};
      run_op(a, b, 1'($urandom), 1'($urandom), $urandom_range(1, 4),
             ($urandom_range(0, 5) == 0) ? $urandom_range(0, N - 1) : N, 0);
      if ($urandom_range(0, 1) == 1) step();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
